// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode constants, ALU op codes and the decoded-instruction record.
// The execute-stage ALU imports the same package, so op codes stay consistent.
package decode_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_SLL = 4'd2,
        ALU_LT  = 4'd3,
        ALU_LTU = 4'd4,
        ALU_XOR = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7,
        ALU_OR  = 4'd8,
        ALU_AND = 4'd9,
        ALU_EQ  = 4'd10,
        ALU_NE  = 4'd11,
        ALU_GE  = 4'd12,
        ALU_GEU = 4'd13
    } alu_op_e;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_op_e     alu_op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        rd_we;
        logic        is_branch;
        logic        is_load;
        logic        is_store;
        logic        is_jump;
        logic        illegal;
        logic [31:0] pc;
        logic [31:0] imm;
    } dec_t;

    localparam dec_t DEC_RESET = '{alu_op: ALU_ADD, a: '0, b: '0, rd: '0, rd_we: 1'b0,
                                   is_branch: 1'b0, is_load: 1'b0, is_store: 1'b0,
                                   is_jump: 1'b0, illegal: 1'b0, pc: '0, imm: '0};

    // alt selects SUB/SRA; callers qualify it so ADDI never becomes a subtract
    function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_LT;
            F3_SLTU: return ALU_LTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch, register-file and execute-side signals of the decode stage.
interface decode_stage_if;
    import decode_stage_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    alu_op_e     alu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        rd_we;
    logic        is_branch;
    logic        is_load;
    logic        is_store;
    logic        is_jump;
    logic        illegal;
    logic [31:0] out_pc;
    logic [31:0] imm;

    modport slave (
        input  in_valid, in_instr, in_pc, rs1_data, rs2_data, flush, out_ready,
        output in_ready, rs1_addr, rs2_addr, out_valid, alu_op, a, b, rd, rd_we,
               is_branch, is_load, is_store, is_jump, illegal, out_pc, imm
    );

    modport master (
        output in_valid, in_instr, in_pc, rs1_data, rs2_data, flush, out_ready,
        input  in_ready, rs1_addr, rs2_addr, out_valid, alu_op, a, b, rd, rd_we,
               is_branch, is_load, is_store, is_jump, illegal, out_pc, imm
    );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// RV32I immediate generator: selects the I/S/B/U/J field and sign-extends it.
// Purely combinational.
module imm_gen
    import decode_stage_pkg::*;
(
    input  logic [31:0] instr_i,
    input  imm_sel_e    sel_i,
    output logic [31:0] imm_o
);
    always_comb begin
        imm_o = '0;
        case (sel_i)
            IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                            instr_i[11:8], 1'b0};
            IMM_U: imm_o = {instr_i[31:12], 12'b0};
            IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                            instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: one registered slot, issue 1 cycle after accept.
// Backpressure: in_ready = !out_valid || out_ready; flush empties the slot and forces in_ready.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter bit ILLEGAL_AS_NOP = 1'b1
) (
    input  logic          clock,
    input  logic          reset_n,
    decode_stage_if.slave bus
);
    logic [31:0] instr;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd_field;
    imm_sel_e    imm_sel;
    logic [31:0] imm_val;

    logic        ill, wr, br, ld, st, jmp;
    alu_op_e     op;
    logic [31:0] opa, opb;

    logic        vld_q, vld_d;
    dec_t        dec_q, dec_d;
    logic        in_ready, load;

    assign instr    = bus.in_instr;
    assign opc      = instr[6:0];
    assign f3       = instr[14:12];
    assign f7       = instr[31:25];
    assign rd_field = instr[11:7];

    assign bus.rs1_addr = instr[19:15];
    assign bus.rs2_addr = instr[24:20];

    always_comb begin
        imm_sel = IMM_NONE;
        case (opc)
            OPC_OPIMM, OPC_JALR, OPC_LOAD: imm_sel = IMM_I;
            OPC_STORE:                     imm_sel = IMM_S;
            OPC_BRANCH:                    imm_sel = IMM_B;
            OPC_LUI, OPC_AUIPC:            imm_sel = IMM_U;
            OPC_JAL:                       imm_sel = IMM_J;
            default:                       imm_sel = IMM_NONE;
        endcase
    end

    imm_gen u_imm_gen (.instr_i(instr), .sel_i(imm_sel), .imm_o(imm_val));

    always_comb begin
        ill = 1'b0; wr = 1'b0; br = 1'b0; ld = 1'b0; st = 1'b0; jmp = 1'b0;
        op  = ALU_ADD;
        opa = bus.rs1_data;
        opb = bus.rs2_data;
        if (instr[1:0] != 2'b11) begin
            ill = 1'b1;
        end else begin
            case (opc)
                OPC_OP: begin
                    wr = 1'b1;
                    op = arith_op(f3, instr[30]);
                    if (f3 == F3_SLL || f3 == F3_SR) opb = {27'b0, bus.rs2_data[4:0]};
                    if (f7 != F7_BASE && !(f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR))) ill = 1'b1;
                end
                OPC_OPIMM: begin
                    wr  = 1'b1;
                    op  = arith_op(f3, (f3 == F3_SR) && instr[30]);
                    opb = imm_val;
                    if (f3 == F3_SLL || f3 == F3_SR) begin
                        opb = {27'b0, instr[24:20]};
                        if (f7 != F7_BASE && !(f7 == F7_ALT && f3 == F3_SR)) ill = 1'b1;
                    end
                end
                OPC_BRANCH: begin
                    br = 1'b1;
                    case (f3)
                        F3_BEQ:  op = ALU_EQ;
                        F3_BNE:  op = ALU_NE;
                        F3_BLT:  op = ALU_LT;
                        F3_BGE:  op = ALU_GE;
                        F3_BLTU: op = ALU_LTU;
                        F3_BGEU: op = ALU_GEU;
                        default: ill = 1'b1;
                    endcase
                end
                OPC_LUI:   begin wr = 1'b1; opa = '0;        opb = imm_val; end
                OPC_AUIPC: begin wr = 1'b1; opa = bus.in_pc; opb = imm_val; end
                OPC_JAL, OPC_JALR: begin
                    wr = 1'b1; jmp = 1'b1; opa = bus.in_pc; opb = 32'd4;
                end
                OPC_LOAD:  begin wr = 1'b1; ld = 1'b1; opb = imm_val; end
                OPC_STORE: begin st = 1'b1; opb = imm_val; end
                default:   ill = 1'b1;
            endcase
        end
    end

    // flush keeps the fetch side moving even while the slot is stalled
    assign in_ready     = !vld_q || bus.out_ready || bus.flush;
    assign bus.in_ready = in_ready;
    assign load         = bus.in_valid && in_ready && !bus.flush;

    always_comb begin
        dec_d = dec_q;
        if (load) begin
            dec_d.pc      = bus.in_pc;
            dec_d.illegal = ill;
            if (ill) begin
                dec_d.alu_op    = ALU_ADD;
                dec_d.a         = ILLEGAL_AS_NOP ? '0 : bus.rs1_data;
                dec_d.b         = ILLEGAL_AS_NOP ? '0 : bus.rs2_data;
                dec_d.rd        = '0;
                dec_d.rd_we     = 1'b0;
                dec_d.is_branch = 1'b0;
                dec_d.is_load   = 1'b0;
                dec_d.is_store  = 1'b0;
                dec_d.is_jump   = 1'b0;
                dec_d.imm       = '0;
            end else begin
                dec_d.alu_op    = op;
                dec_d.a         = opa;
                dec_d.b         = opb;
                dec_d.rd        = wr ? rd_field : 5'd0;
                dec_d.rd_we     = wr && (rd_field != 5'd0);
                dec_d.is_branch = br;
                dec_d.is_load   = ld;
                dec_d.is_store  = st;
                dec_d.is_jump   = jmp;
                dec_d.imm       = imm_val;
            end
        end
    end

    assign vld_d = bus.flush ? 1'b0 : load ? 1'b1 : bus.out_ready ? 1'b0 : vld_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= 1'b0;
            dec_q <= DEC_RESET;
        end else begin
            vld_q <= vld_d;
            dec_q <= dec_d;
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.alu_op    = dec_q.alu_op;
    assign bus.a         = dec_q.a;
    assign bus.b         = dec_q.b;
    assign bus.rd        = dec_q.rd;
    assign bus.rd_we     = dec_q.rd_we;
    assign bus.is_branch = dec_q.is_branch;
    assign bus.is_load   = dec_q.is_load;
    assign bus.is_store  = dec_q.is_store;
    assign bus.is_jump   = dec_q.is_jump;
    assign bus.illegal   = dec_q.illegal;
    assign bus.out_pc    = dec_q.pc;
    assign bus.imm       = dec_q.imm;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed RV32I cases, then random traffic.
module tb_decode_stage;
    import decode_stage_pkg::*;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we, br, ld, st, jmp, ill;
        logic [31:0] pc;
        logic [31:0] imm;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    decode_stage_if bus();
    decode_stage dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    always #5 clock = ~clock;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    logic ov = 1'b0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic logic [31:0] sra(input logic [31:0] v, input int n);
        return $signed(v) >>> n;
    endfunction

    // Reference decode written straight from the RV32I field layout.
    function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [31:0] iimm, simm, bimm, uimm, jimm;
        logic writes, ill;
        f7   = ins[31:25];
        f3   = ins[14:12];
        iimm = sra(ins, 20);
        simm = sra({ins[31:25], ins[11:7], 20'b0}, 20);
        bimm = sra({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 19'b0}, 19);
        uimm = {ins[31:12], 12'b0};
        jimm = sra({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 11'b0}, 11);
        e = '0; e.op = ALU_ADD; e.pc = pc; writes = 1'b0; ill = 1'b0;
        if (ins[1:0] != 2'b11) ill = 1'b1;
        else case (ins[6:0])
            7'h33: begin
                writes = 1'b1; e.a = r1; e.b = r2;
                case (f3)
                    3'd0: e.op = (f7 == 7'h20) ? ALU_SUB : ALU_ADD;
                    3'd1: e.op = ALU_SLL;
                    3'd2: e.op = ALU_LT;
                    3'd3: e.op = ALU_LTU;
                    3'd4: e.op = ALU_XOR;
                    3'd5: e.op = (f7 == 7'h20) ? ALU_SRA : ALU_SRL;
                    3'd6: e.op = ALU_OR;
                    default: e.op = ALU_AND;
                endcase
                if (f3 == 3'd1 || f3 == 3'd5) e.b = r2 % 32;
                if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) ill = 1'b1;
            end
            7'h13: begin
                writes = 1'b1; e.a = r1; e.b = iimm; e.imm = iimm;
                case (f3)
                    3'd0: e.op = ALU_ADD;
                    3'd1: begin e.op = ALU_SLL; e.b = {27'b0, ins[24:20]}; ill = (f7 != 7'h00); end
                    3'd2: e.op = ALU_LT;
                    3'd3: e.op = ALU_LTU;
                    3'd4: e.op = ALU_XOR;
                    3'd5: begin
                        e.b = {27'b0, ins[24:20]};
                        if (f7 == 7'h00) e.op = ALU_SRL;
                        else if (f7 == 7'h20) e.op = ALU_SRA;
                        else ill = 1'b1;
                    end
                    3'd6: e.op = ALU_OR;
                    default: e.op = ALU_AND;
                endcase
            end
            7'h63: begin
                e.br = 1'b1; e.a = r1; e.b = r2; e.imm = bimm;
                case (f3)
                    3'd0: e.op = ALU_EQ;
                    3'd1: e.op = ALU_NE;
                    3'd4: e.op = ALU_LT;
                    3'd5: e.op = ALU_GE;
                    3'd6: e.op = ALU_LTU;
                    3'd7: e.op = ALU_GEU;
                    default: ill = 1'b1;
                endcase
            end
            7'h37: begin writes = 1'b1; e.a = 32'd0; e.b = uimm; e.imm = uimm; end
            7'h17: begin writes = 1'b1; e.a = pc;    e.b = uimm; e.imm = uimm; end
            7'h6F: begin writes = 1'b1; e.jmp = 1'b1; e.a = pc; e.b = 32'd4; e.imm = jimm; end
            7'h67: begin writes = 1'b1; e.jmp = 1'b1; e.a = pc; e.b = 32'd4; e.imm = iimm; end
            7'h03: begin writes = 1'b1; e.ld = 1'b1; e.a = r1; e.b = iimm; e.imm = iimm; end
            7'h23: begin e.st = 1'b1; e.a = r1; e.b = simm; e.imm = simm; end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            e = '0; e.op = ALU_ADD; e.pc = pc; e.ill = 1'b1;
        end else begin
            e.rd = writes ? ins[11:7] : 5'd0;
            e.we = writes && (ins[11:7] != 5'd0);
        end
        return e;
    endfunction

    function automatic exp_t pack_dut();
        exp_t e;
        e.op = bus.alu_op; e.a = bus.a; e.b = bus.b; e.rd = bus.rd; e.we = bus.rd_we;
        e.br = bus.is_branch; e.ld = bus.is_load; e.st = bus.is_store;
        e.jmp = bus.is_jump; e.ill = bus.illegal; e.pc = bus.out_pc; e.imm = bus.imm;
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int sel;
        w   = $urandom;
        sel = $urandom_range(0, 11);
        case (sel)
            0: begin
                w[6:0] = 7'h33;
                if (w[14:12] == 3'd0 || w[14:12] == 3'd5) w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
                else w[31:25] = 7'h00;
            end
            1, 2: begin
                w[6:0] = 7'h13;
                if (w[14:12] == 3'd1 || w[14:12] == 3'd5)
                    case ($urandom_range(0, 2))
                        0: w[31:25] = 7'h00;
                        1: w[31:25] = 7'h20;
                        default: ;
                    endcase
            end
            3: w[6:0] = 7'h63;
            4: w[6:0] = 7'h37;
            5: w[6:0] = 7'h17;
            6: w[6:0] = 7'h6F;
            7: begin w[6:0] = 7'h67; w[14:12] = 3'd0; end
            8: w[6:0] = 7'h03;
            9: w[6:0] = 7'h23;
            10: ;
            default: w[1:0] = 2'($urandom_range(0, 2));
        endcase
        return w;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic fl, input logic ordy);
        @(posedge clock);
        #1;
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.in_pc     = pc;
        bus.rs1_data  = r1;
        bus.rs2_data  = r2;
        bus.flush     = fl;
        bus.out_ready = ordy;
    endtask

    task automatic check_reset(input string tag);
        exp_t r;
        r = '0; r.op = ALU_ADD;
        chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
        chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
        chk({tag, "_outputs"}, pack_dut(), r);
    endtask

    // Expected slot occupancy and scoreboard updated on every accepting edge
    always @(posedge clock or negedge reset_n) begin
        logic rdy, acc;
        if (!reset_n) begin
            ov = 1'b0;
            sb.delete();
        end else begin
            rdy = !ov || bus.out_ready || bus.flush;
            acc = bus.in_valid && rdy && !bus.flush;
            if (bus.flush) sb.delete();
            if (acc) sb.push_back(ref_model(bus.in_instr, bus.in_pc, bus.rs1_data, bus.rs2_data));
            ov = bus.flush ? 1'b0 : acc ? 1'b1 : bus.out_ready ? 1'b0 : ov;
        end
    end

    logic stalled  = 1'b0;
    logic stall_fl = 1'b0;
    exp_t held;

    always @(negedge clock) begin
        exp_t act;
        if (!reset_n) begin
            stalled = 1'b0;
        end else begin
            act = pack_dut();
            chk("out_valid", bus.out_valid, ov);
            chk("in_ready", bus.in_ready, !ov || bus.out_ready || bus.flush);
            chk("rs1_addr", bus.rs1_addr, bus.in_instr[19:15]);
            chk("rs2_addr", bus.rs2_addr, bus.in_instr[24:20]);
            if (stalled && !stall_fl) chk("stall_hold", act, held);
            if (bus.out_valid && bus.out_ready && !bus.flush) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_empty: issue with nothing expected pc=%h", bus.out_pc);
                end else begin
                    chk("payload", act, sb.pop_front());
                end
            end
            stalled  = bus.out_valid && !bus.out_ready;
            stall_fl = bus.flush;
            held     = act;
        end
    end

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SRAI = 32'h40335293;
    localparam logic [31:0] I_SLL  = 32'h007312B3;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_ADDI = 32'h00100093;

    initial begin
        int n;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
        bus.rs1_data = '0;   bus.rs2_data = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        @(negedge clock);
        check_reset("por");
        @(posedge clock);
        #1 reset_n = 1'b1;

        drive(1, I_ADD,  32'h100, 32'd5, 32'd7, 0, 1);
        drive(1, I_SRAI, 32'h104, 32'h80000000, 32'd0, 0, 1);
        drive(1, I_SLL,  32'h108, 32'h1234, 32'h25, 0, 1);
        drive(1, I_BEQ,  32'h10C, 32'd1, 32'd1, 0, 1);
        drive(1, 32'h0,  32'h110, 32'd9, 32'd9, 0, 1);
        // two stalled cycles with a waiting instruction, then release
        drive(1, I_ADD,  32'h114, 32'd5, 32'd7, 0, 0);
        drive(1, I_ADDI, 32'h118, 32'd3, 32'd3, 0, 0);
        drive(1, I_ADDI, 32'h118, 32'd3, 32'd3, 0, 0);
        drive(1, I_ADDI, 32'h118, 32'd3, 32'd3, 0, 1);
        drive(0, 32'h0,  32'h0,   32'd0, 32'd0, 0, 1);
        drive(1, I_ADD,  32'h11C, 32'd5, 32'd7, 1, 1);
        drive(0, 32'h0,  32'h0,   32'd0, 32'd0, 0, 1);
        // flush while stalled
        drive(1, I_ADD,  32'h120, 32'd1, 32'd2, 0, 0);
        drive(1, I_ADDI, 32'h124, 32'd1, 32'd2, 0, 0);
        drive(1, I_ADDI, 32'h124, 32'd1, 32'd2, 1, 0);
        drive(0, 32'h0,  32'h0,   32'd0, 32'd0, 0, 1);
        // reset in the middle of a stall
        drive(1, I_SRAI, 32'h128, 32'h80000000, 32'd0, 0, 0);
        drive(1, I_ADDI, 32'h12C, 32'd1, 32'd2, 0, 0);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check_reset("mid_stall");
        drive(0, 32'h0, 32'h0, 32'd0, 32'd0, 0, 1);
        drive(0, 32'h0, 32'h0, 32'd0, 32'd0, 0, 1);
        reset_n = 1'b1;
        drive(1, I_ADD, 32'h200, 32'd5, 32'd7, 0, 1);
        drive(0, 32'h0, 32'h0,   32'd0, 32'd0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 8, gen_instr(), $urandom & 32'hFFFF_FFFC,
                  $urandom, $urandom, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
        end

        n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 20) begin
            drive(0, 32'h0, 32'h0, 32'd0, 32'd0, 0, 1);
            n++;
        end
        @(negedge clock);
        chk("drain_valid", bus.out_valid, 1'b0);
        chk("drain_sb", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
